// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_pkg;

    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the SRAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until ack; controller strobes are held until done.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = sram_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_pkg::DEF_DATA_WIDTH
) ();

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_oen;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_done;

    // Arbiter view: serves the two requesters and drives the RAM controller.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_data_out, mem_done,
        output ack0, ack1, rdata,
        output mem_oen, mem_wen, mem_addr, mem_data_in
    );

    // Environment view: the requesters plus the RAM controller.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_data_out, mem_done,
        input  ack0, ack1, rdata,
        input  mem_oen, mem_wen, mem_addr, mem_data_in
    );

endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-request round-robin picker: sole requester wins, contested pick goes to ptr.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the pick is consumed.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt_valid,
    output logic gnt_id
);

    // Pick the winner from the current request levels and the priority pointer.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = (req0 & req1) ? ptr : req1;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one RAM controller between fetch (port 0) and data (port 1).
// Latency: strobe one edge after grant sample; ack one edge after done is sampled high.
// Backpressure: one transaction in flight; no grant until controller drops done.
module sram_arbiter #(
    parameter int ADDR_WIDTH = sram_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_pkg::DEF_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    import sram_pkg::*;

    state_t                state, state_nxt;
    logic                  ptr, ptr_nxt;
    logic                  gnt_id, gnt_id_nxt;
    logic                  we_q, we_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
    logic                  oen_q, oen_nxt;
    logic                  wen_q, wen_nxt;
    logic                  ack0_q, ack0_nxt;
    logic                  ack1_q, ack1_nxt;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;
    logic                  pick_vld;
    logic                  pick_id;

    rr_pick2 u_pick (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .ptr       (ptr),
        .gnt_valid (pick_vld),
        .gnt_id    (pick_id)
    );

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_id_nxt = gnt_id;
        we_nxt     = we_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        oen_nxt    = oen_q;
        wen_nxt    = wen_q;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        rdata_nxt  = rdata_q;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_id_nxt = pick_id;
                    we_nxt     = pick_id ? bus.we1    : bus.we0;
                    addr_nxt   = pick_id ? bus.addr1  : bus.addr0;
                    wdata_nxt  = pick_id ? bus.wdata1 : bus.wdata0;
                    oen_nxt    = we_nxt;
                    wen_nxt    = ~we_nxt;
                    // Only a contested grant moves priority away from the winner.
                    if (bus.req0 && bus.req1) begin
                        ptr_nxt = ~ptr;
                    end
                    state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_done) begin
                    if (!we_q) begin
                        rdata_nxt = bus.mem_data_out;
                    end
                    oen_nxt   = 1'b1;
                    wen_nxt   = 1'b1;
                    ack0_nxt  = ~gnt_id;
                    ack1_nxt  = gnt_id;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // A done left high from the last transaction must not finish the next one.
                if (!bus.mem_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer, transaction latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            gnt_id  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oen_q   <= 1'b1;
            wen_q   <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_id  <= gnt_id_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            oen_q   <= oen_nxt;
            wen_q   <= wen_nxt;
            ack0_q  <= ack0_nxt;
            ack1_q  <= ack1_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    assign bus.mem_oen     = oen_q;
    assign bus.mem_wen     = wen_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata       = rdata_q;

endmodule
